// File: rtl/csr_regfile.sv
// csr_regfile: LoongArch CSR file (CRMD..TICLR) with exception/ERTN state update and countdown timer
module csr_regfile #(
  parameter int CSR_NUM_WIDTH = 14
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     csr_re,
  input  logic [CSR_NUM_WIDTH-1:0] csr_num,
  output logic [31:0]              csr_rvalue,
  input  logic                     csr_we,
  input  logic [31:0]              csr_wmask,
  input  logic [31:0]              csr_wvalue,
  input  logic                     wb_ex,
  input  logic [5:0]               wb_ecode,
  input  logic [8:0]               wb_esubcode,
  input  logic [31:0]              wb_pc,
  input  logic                     ertn_flush,
  input  logic [7:0]               hw_int_in,
  output logic [1:0]               csr_plv,
  output logic [31:0]              ex_entry,
  output logic [31:0]              ertn_entry,
  output logic                     has_int
);
  localparam logic [CSR_NUM_WIDTH-1:0] CRMD   = 'h0;
  localparam logic [CSR_NUM_WIDTH-1:0] PRMD   = 'h1;
  localparam logic [CSR_NUM_WIDTH-1:0] ECFG   = 'h4;
  localparam logic [CSR_NUM_WIDTH-1:0] ESTAT  = 'h5;
  localparam logic [CSR_NUM_WIDTH-1:0] ERA    = 'h6;
  localparam logic [CSR_NUM_WIDTH-1:0] EENTRY = 'hc;
  localparam logic [CSR_NUM_WIDTH-1:0] SAVE0  = 'h30;
  localparam logic [CSR_NUM_WIDTH-1:0] SAVE1  = 'h31;
  localparam logic [CSR_NUM_WIDTH-1:0] SAVE2  = 'h32;
  localparam logic [CSR_NUM_WIDTH-1:0] SAVE3  = 'h33;
  localparam logic [CSR_NUM_WIDTH-1:0] TID    = 'h40;
  localparam logic [CSR_NUM_WIDTH-1:0] TCFG   = 'h41;
  localparam logic [CSR_NUM_WIDTH-1:0] TVAL   = 'h42;
  localparam logic [CSR_NUM_WIDTH-1:0] TICLR  = 'h44;
  logic [8:0]  crmd;
  logic [2:0]  prmd;
  logic [12:0] ecfg;
  logic [1:0]  is_sw;
  logic [7:0]  is_hw;
  logic        ti;
  logic [5:0]  ecode;
  logic [8:0]  esubcode;
  logic [31:0] era, tid, tcfg, tval;
  logic [25:0] eentry;
  logic [31:0] save [4];
  logic [12:0] is_all;
  logic [31:0] wd;
  logic        wr, tcfg_load, fire, unused_re;
  assign unused_re = csr_re;
  assign is_all = {1'b0, ti, 1'b0, is_hw, is_sw};
  always_comb begin
    csr_rvalue = 32'h0;
    case (csr_num)
      CRMD:   csr_rvalue = {23'h0, crmd};
      PRMD:   csr_rvalue = {29'h0, prmd};
      ECFG:   csr_rvalue = {19'h0, ecfg};
      ESTAT:  csr_rvalue = {1'b0, esubcode, ecode, 3'h0, is_all};
      ERA:    csr_rvalue = era;
      EENTRY: csr_rvalue = {eentry, 6'h0};
      SAVE0, SAVE1, SAVE2, SAVE3: csr_rvalue = save[csr_num[1:0]];
      TID:    csr_rvalue = tid;
      TCFG:   csr_rvalue = tcfg;
      TVAL:   csr_rvalue = tval;
      default: csr_rvalue = 32'h0;
    endcase
  end
  // merging against the current read value gives every register its masked update
  assign wd        = (csr_rvalue & ~csr_wmask) | (csr_wvalue & csr_wmask);
  assign wr        = csr_we & ~wb_ex & ~ertn_flush;
  assign tcfg_load = wr && csr_num == TCFG && wd[0];
  assign fire      = !tcfg_load && tcfg[0] && tval == 32'h1;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      crmd     <= 9'h8;
      prmd     <= '0;
      ecfg     <= '0;
      is_sw    <= '0;
      is_hw    <= '0;
      ti       <= 1'b0;
      ecode    <= '0;
      esubcode <= '0;
      era      <= '0;
      eentry   <= '0;
      save     <= '{default: '0};
      tid      <= '0;
      tcfg     <= '0;
      tval     <= '0;
    end else begin
      is_hw <= hw_int_in;
      if (ertn_flush) crmd[2:0] <= prmd;
      else if (wb_ex) begin
        prmd      <= crmd[2:0];
        crmd[2:0] <= 3'h0;
        ecode     <= wb_ecode;
        esubcode  <= wb_esubcode;
        era       <= wb_pc;
      end else if (csr_we) begin
        case (csr_num)
          CRMD:   crmd   <= wd[8:0];
          PRMD:   prmd   <= wd[2:0];
          ECFG:   ecfg   <= wd[12:0] & 13'h1bff;
          ESTAT:  is_sw  <= wd[1:0];
          ERA:    era    <= wd;
          EENTRY: eentry <= wd[31:6];
          SAVE0, SAVE1, SAVE2, SAVE3: save[csr_num[1:0]] <= wd;
          TID:    tid    <= wd;
          TCFG:   tcfg   <= wd;
          default: ;
        endcase
      end
      if (tcfg_load) tval <= {wd[31:2], 2'b00};
      else if (tcfg[0] && tval != 32'h0) tval <= (fire && tcfg[1]) ? {tcfg[31:2], 2'b00} : tval - 32'h1;
      // a timer expiry in the same cycle as a TICLR clear keeps the interrupt
      if (fire) ti <= 1'b1;
      else if (wr && csr_num == TICLR && wd[0]) ti <= 1'b0;
    end
  end
  assign csr_plv    = crmd[1:0];
  assign ex_entry   = {eentry, 6'h0};
  assign ertn_entry = era;
  assign has_int    = crmd[2] & |(is_all & ecfg);
endmodule

// File: tb/tb_csr_regfile.sv
// tb_csr_regfile: directed scoreboard bench for csr_regfile
module tb_csr_regfile;
  logic        clk = 1'b0, reset = 1'b1, csr_re = 1'b1, csr_we = 1'b0;
  logic        wb_ex = 1'b0, ertn_flush = 1'b0, has_int;
  logic [13:0] csr_num = '0;
  logic [31:0] csr_wmask = '0, csr_wvalue = '0, wb_pc = '0;
  logic [31:0] csr_rvalue, ex_entry, ertn_entry;
  logic [5:0]  wb_ecode = '0;
  logic [8:0]  wb_esubcode = '0;
  logic [7:0]  hw_int_in = '0;
  logic [1:0]  csr_plv;
  int checks = 0, errors = 0;
  string       tq[$];
  int          kq[$];
  logic [13:0] aq[$];
  logic [31:0] vq[$];
  csr_regfile #(.CSR_NUM_WIDTH(14)) dut (
    .clk(clk), .reset(reset), .csr_re(csr_re), .csr_num(csr_num), .csr_rvalue(csr_rvalue),
    .csr_we(csr_we), .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue), .wb_ex(wb_ex),
    .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode), .wb_pc(wb_pc), .ertn_flush(ertn_flush),
    .hw_int_in(hw_int_in), .csr_plv(csr_plv), .ex_entry(ex_entry), .ertn_entry(ertn_entry),
    .has_int(has_int)
  );
  always #10 clk = ~clk;
  task automatic push(string t, int k, logic [13:0] a, logic [31:0] v);
    tq.push_back(t);
    kq.push_back(k);
    aq.push_back(a);
    vq.push_back(v);
  endtask
  task automatic ec(string t, logic [13:0] a, logic [31:0] v);
    push(t, 0, a, v);
  endtask
  task automatic drain();
    string t;
    int k;
    logic [31:0] v, o;
    while (kq.size() > 0) begin
      t = tq.pop_front();
      k = kq.pop_front();
      v = vq.pop_front();
      csr_num = aq.pop_front();
      #1;
      o = k == 0 ? csr_rvalue : k == 1 ? {30'h0, csr_plv} : k == 2 ? {31'h0, has_int} :
          k == 3 ? ex_entry : ertn_entry;
      checks++;
      assert (o === v) else begin
        errors++;
        $error("FAIL %s: got %h expected %h", t, o, v);
      end
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(logic [13:0] a, logic [31:0] m, logic [31:0] v);
    csr_num = a;
    csr_wmask = m;
    csr_wvalue = v;
    csr_we = 1'b1;
    tick();
    csr_we = 1'b0;
  endtask
  initial begin
    tick();
    tick();
    reset = 1'b0;
    tick();
    ec("rst_crmd", 14'h0, 32'h8);
    ec("rst_prmd", 14'h1, 0);
    ec("rst_ecfg", 14'h4, 0);
    ec("rst_estat", 14'h5, 0);
    ec("rst_era", 14'h6, 0);
    ec("rst_eentry", 14'hc, 0);
    ec("rst_save0", 14'h30, 0);
    ec("rst_tid", 14'h40, 0);
    ec("rst_tcfg", 14'h41, 0);
    ec("rst_tval", 14'h42, 0);
    ec("rst_ticlr", 14'h44, 0);
    push("rst_plv", 1, 0, 0);
    push("rst_has_int", 2, 0, 0);
    push("rst_ex_entry", 3, 0, 0);
    push("rst_ertn_entry", 4, 0, 0);
    drain();
    wr(14'h30, 32'hffffffff, 32'haaaaaaaa);
    wr(14'h30, 32'h0000ffff, 32'h12345678);
    ec("save0_mask", 14'h30, 32'haaaa5678);
    wr(14'h7, 32'hffffffff, 32'hffffffff);
    ec("unmapped", 14'h7, 0);
    wr(14'hc, 32'hffffffff, 32'hffffffff);
    ec("eentry", 14'hc, 32'hffffffc0);
    push("ex_entry", 3, 0, 32'hffffffc0);
    wr(14'h4, 32'hffffffff, 32'hffffffff);
    ec("ecfg", 14'h4, 32'h1bff);
    wr(14'h5, 32'hffffffff, 32'hffffffff);
    ec("estat_wr", 14'h5, 32'h3);
    drain();
    wr(14'h5, 32'hffffffff, 32'h0);
    wr(14'h42, 32'hffffffff, 32'h1234);
    ec("tval_ro", 14'h42, 0);
    drain();
    csr_num = 14'h32;
    csr_wmask = 32'hffffffff;
    csr_wvalue = 32'h99;
    csr_we = 1'b1;
    ec("save2_old", 14'h32, 0);
    drain();
    tick();
    csr_we = 1'b0;
    ec("save2_new", 14'h32, 32'h99);
    drain();
    wr(14'h0, 32'hffffffff, 32'h7);
    ec("crmd7", 14'h0, 32'h7);
    push("plv3", 1, 0, 3);
    drain();
    wb_ex = 1'b1;
    wb_ecode = 6'hb;
    wb_esubcode = 9'h5;
    wb_pc = 32'h1c000100;
    tick();
    wb_ex = 1'b0;
    ec("ex_crmd", 14'h0, 0);
    ec("ex_prmd", 14'h1, 32'h7);
    ec("ex_estat", 14'h5, 32'h014b0000);
    ec("ex_era", 14'h6, 32'h1c000100);
    push("ex_plv", 1, 0, 0);
    drain();
    ertn_flush = 1'b1;
    tick();
    ertn_flush = 1'b0;
    ec("ertn_crmd", 14'h0, 32'h7);
    ec("ertn_prmd", 14'h1, 32'h7);
    push("ertn_plv", 1, 0, 3);
    push("ertn_entry", 4, 0, 32'h1c000100);
    drain();
    csr_num = 14'h31;
    csr_wmask = 32'hffffffff;
    csr_wvalue = 32'h55;
    csr_we = 1'b1;
    wb_ex = 1'b1;
    wb_pc = 32'h1c000200;
    tick();
    csr_we = 1'b0;
    wb_ex = 1'b0;
    ec("drop_save1", 14'h31, 0);
    ec("drop_era", 14'h6, 32'h1c000200);
    ec("drop_crmd", 14'h0, 0);
    drain();
    csr_num = 14'h31;
    csr_we = 1'b1;
    wb_ex = 1'b1;
    ertn_flush = 1'b1;
    wb_pc = 32'h1c000300;
    tick();
    csr_we = 1'b0;
    wb_ex = 1'b0;
    ertn_flush = 1'b0;
    ec("both_crmd", 14'h0, 32'h7);
    ec("both_era", 14'h6, 32'h1c000200);
    ec("both_save1", 14'h31, 0);
    ec("both_prmd", 14'h1, 32'h7);
    drain();
    hw_int_in = 8'h5a;
    tick();
    ec("hw_estat", 14'h5, 32'h014b0168);
    push("hw_has_int", 2, 0, 1);
    drain();
    hw_int_in = 8'h0;
    wr(14'h4, 32'hffffffff, 32'h800);
    ec("ecfg800", 14'h4, 32'h800);
    push("no_int", 2, 0, 0);
    drain();
    wr(14'h41, 32'hffffffff, 32'hb);
    ec("tcfg", 14'h41, 32'hb);
    ec("tval_load", 14'h42, 32'h8);
    drain();
    for (int i = 7; i >= 1; i--) begin
      tick();
      ec("tval_count", 14'h42, i);
      drain();
    end
    tick();
    ec("tval_reload", 14'h42, 32'h8);
    ec("ti_estat", 14'h5, 32'h014b0800);
    push("ti_has_int", 2, 0, 1);
    drain();
    wr(14'h44, 32'hffffffff, 32'h1);
    ec("ticlr_estat", 14'h5, 32'h014b0000);
    ec("ticlr_tval", 14'h42, 32'h7);
    ec("ticlr_read", 14'h44, 0);
    push("ticlr_has_int", 2, 0, 0);
    drain();
    tick();
    tick();
    ec("tval5", 14'h42, 32'h5);
    drain();
    #3;
    reset = 1'b1;
    #1;
    ec("arst_tval", 14'h42, 0);
    ec("arst_crmd", 14'h0, 32'h8);
    push("arst_plv", 1, 0, 0);
    drain();
    tick();
    reset = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
